disparity_accumulate: RTL and testbench

Streaming accumulator directly downstream of the four-way window-sum comparator tree. Each beat delivers the winning (disparity, window_sum) pair of one group of four disparity candidates. Over NUM_GROUPS beats per pixel the block keeps the running minimum and the runner-up. It then emits the final per-pixel disparity, its window sum and a confidence flag through a one-entry output register with valid/ready backpressure.

---
 rtl/disparity_accumulate_if.sv | 45 ++++
 rtl/disparity_accumulate.sv | 117 +++++++++++
 tb/tb_disparity_accumulate.sv | 314 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/disparity_accumulate_if.sv
// Bundle of the streaming signals around disparity_accumulate.
//
// Handshake semantics (both channels): a transfer happens on a rising clock
// edge where valid && ready are both high. A producer holding valid must keep
// its payload stable until that edge; ready may depend combinationally on the
// consumer's state and on the opposite channel's ready, never on valid.
//
// Signals:
//   frame_start    upstream -> block, one-cycle pulse, drops partial pixel
//   in_valid       upstream -> block, group winner present
//   in_ready       block -> upstream, beat accepted when in_valid && in_ready
//   in_disparity   upstream -> block, disparity of group winner
//   in_window_sum  upstream -> block, window sum of group winner
//   out_valid      block -> downstream, result held in output register
//   out_ready      downstream -> block, result consumed when out_valid && out_ready
//   out_disparity  block -> downstream, disparity with minimum window sum
//   out_window_sum block -> downstream, that minimum window sum
//   out_confident  block -> downstream, runner-up margin >= threshold
interface disparity_accumulate_if #(
  parameter int DISP_W = 6,
  parameter int WS_W   = 14
);
  logic              frame_start;
  logic              in_valid;
  logic              in_ready;
  logic [DISP_W-1:0] in_disparity;
  logic [WS_W-1:0]   in_window_sum;
  logic              out_valid;
  logic              out_ready;
  logic [DISP_W-1:0] out_disparity;
  logic [WS_W-1:0]   out_window_sum;
  logic              out_confident;

  // Driver side: the upstream comparator tree plus the downstream consumer.
  modport master (
    output frame_start, in_valid, in_disparity, in_window_sum, out_ready,
    input  in_ready, out_valid, out_disparity, out_window_sum, out_confident
  );

  // Accumulator side.
  modport slave (
    input  frame_start, in_valid, in_disparity, in_window_sum, out_ready,
    output in_ready, out_valid, out_disparity, out_window_sum, out_confident
  );
endinterface

// File: rtl/disparity_accumulate.sv
// Streaming per-pixel disparity accumulator.
//
// Takes NUM_GROUPS group winners per pixel, tracks the smallest window sum
// (earliest wins ties) and the runner-up, and presents the pixel result in a
// one-entry output register with valid/ready backpressure.
//
// Ports:
//   clock  single clock, rising edge
//   reset  synchronous, active-high
//   bus    disparity_accumulate_if.slave (input beats, frame_start, output result)
module disparity_accumulate #(
  parameter int unsigned     NUM_GROUPS  = 16,
  parameter int unsigned     WS_W        = 14,
  parameter int unsigned     DISP_W      = 6,
  parameter logic [WS_W-1:0] CONF_THRESH = WS_W'(64)
) (
  input logic                    clock,
  input logic                    reset,
  disparity_accumulate_if.slave  bus
);

  localparam int unsigned     CNT_W = (NUM_GROUPS > 1) ? $clog2(NUM_GROUPS) : 1;
  localparam logic [CNT_W-1:0] LAST_GRP = CNT_W'(NUM_GROUPS - 1);
  localparam logic [WS_W-1:0]  WS_ONES  = '1;

  // Accumulator state
  logic [CNT_W-1:0]  grp_cnt;
  logic [WS_W-1:0]   best_ws;
  logic [DISP_W-1:0] best_disp;
  logic [WS_W-1:0]   second_ws;

  // Output register
  logic              out_valid_q;
  logic [DISP_W-1:0] out_disp_q;
  logic [WS_W-1:0]   out_ws_q;
  logic              out_conf_q;

  // Combinational next values
  logic              in_ready_c;
  logic              accept;
  logic [CNT_W-1:0]  eff_cnt;
  logic              first_beat;
  logic              last_beat;
  logic [WS_W-1:0]   nxt_best_ws;
  logic [DISP_W-1:0] nxt_best_disp;
  logic [WS_W-1:0]   nxt_second_ws;
  logic [WS_W-1:0]   margin;
  logic              nxt_conf;

  always_comb begin
    // Stall only while a result is stuck in the output register.
    in_ready_c    = !reset && !(out_valid_q && !bus.out_ready);
    accept        = bus.in_valid && in_ready_c;
    // A frame_start beat is treated as the first group of a fresh pixel.
    eff_cnt       = bus.frame_start ? '0 : grp_cnt;
    first_beat    = (eff_cnt == '0);
    last_beat     = (eff_cnt == LAST_GRP);

    nxt_best_ws   = best_ws;
    nxt_best_disp = best_disp;
    nxt_second_ws = second_ws;
    if (first_beat) begin
      nxt_best_ws   = bus.in_window_sum;
      nxt_best_disp = bus.in_disparity;
      nxt_second_ws = WS_ONES;
    end else if (bus.in_window_sum < best_ws) begin
      nxt_second_ws = best_ws;
      nxt_best_ws   = bus.in_window_sum;
      nxt_best_disp = bus.in_disparity;
    end else if (bus.in_window_sum < second_ws) begin
      nxt_second_ws = bus.in_window_sum;
    end

    // second >= best always holds, so the subtract cannot wrap.
    margin   = nxt_second_ws - nxt_best_ws;
    nxt_conf = (margin >= CONF_THRESH);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      grp_cnt     <= '0;
      best_ws     <= WS_ONES;
      best_disp   <= '0;
      second_ws   <= WS_ONES;
      out_valid_q <= 1'b0;
      out_disp_q  <= '0;
      out_ws_q    <= '0;
      out_conf_q  <= 1'b0;
    end else begin
      if (accept) begin
        grp_cnt   <= last_beat ? '0 : eff_cnt + CNT_W'(1);
        best_ws   <= nxt_best_ws;
        best_disp <= nxt_best_disp;
        second_ws <= nxt_second_ws;
      end else if (bus.frame_start) begin
        grp_cnt <= '0;
      end

      // A final beat wins over a simultaneous consume.
      if (accept && last_beat) begin
        out_valid_q <= 1'b1;
        out_disp_q  <= nxt_best_disp;
        out_ws_q    <= nxt_best_ws;
        out_conf_q  <= nxt_conf;
      end else if (bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign bus.in_ready       = in_ready_c;
  assign bus.out_valid      = out_valid_q;
  assign bus.out_disparity  = out_disp_q;
  assign bus.out_window_sum = out_ws_q;
  assign bus.out_confident  = out_conf_q;

endmodule

// File: tb/tb_disparity_accumulate.sv
module tb_disparity_accumulate;
  localparam int NG     = 16;
  localparam int WS_W   = 14;
  localparam int DISP_W = 6;
  localparam int THRESH = 64;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  disparity_accumulate_if #(.DISP_W(DISP_W), .WS_W(WS_W)) bus ();

  disparity_accumulate #(
    .NUM_GROUPS (NG),
    .WS_W       (WS_W),
    .DISP_W     (DISP_W),
    .CONF_THRESH(14'd64)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d time=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Collects the beats of the current pixel; on the last one the result is
  // computed from the whole pixel: smallest sum (earliest index on ties) and
  // the second smallest value of the multiset.
  logic [WS_W-1:0]   exp_q[$];
  logic [DISP_W-1:0] exp_disp_q[$];
  logic              m_valid = 1'b0;
  logic [DISP_W-1:0] m_disp  = '0;
  logic [WS_W-1:0]   m_ws    = '0;
  logic              m_conf  = 1'b0;
  int                results = 0;
  int                cyc     = 0;
  logic              m_rdy, m_acc, m_loaded;
  int                m_bi, m_sec;

  always @(posedge clock) begin
    cyc++;
    if (reset) begin
      exp_q.delete();
      exp_disp_q.delete();
      m_valid = 1'b0;
      m_disp  = '0;
      m_ws    = '0;
      m_conf  = 1'b0;
    end else begin
      m_rdy    = !(m_valid && !bus.out_ready);
      m_acc    = bus.in_valid && m_rdy;
      m_loaded = 1'b0;
      if (bus.frame_start) begin
        exp_q.delete();
        exp_disp_q.delete();
      end
      if (m_acc) begin
        exp_q.push_back(bus.in_window_sum);
        exp_disp_q.push_back(bus.in_disparity);
        if (exp_q.size() == NG) begin
          m_bi = 0;
          for (int i = 1; i < NG; i++)
            if (int'(exp_q[i]) < int'(exp_q[m_bi])) m_bi = i;
          m_sec = (1 << WS_W) - 1;
          for (int i = 0; i < NG; i++)
            if (i != m_bi && int'(exp_q[i]) < m_sec) m_sec = int'(exp_q[i]);
          m_valid  = 1'b1;
          m_ws     = exp_q[m_bi];
          m_disp   = exp_disp_q[m_bi];
          m_conf   = (m_sec - int'(exp_q[m_bi])) >= THRESH;
          m_loaded = 1'b1;
          results++;
          exp_q.delete();
          exp_disp_q.delete();
        end
      end
      if (!m_loaded && bus.out_ready) m_valid = 1'b0;
    end
  end

  // ---------------- compare process ----------------
  logic cmp_en = 1'b0;
  logic rec    = 1'b0;
  logic prev_ov = 1'b0;
  int   rises  = 0;
  int   pulse_q[$];

  always @(negedge clock) begin
    if (cmp_en) begin
      chk("in_ready", bus.in_ready, !reset && !(m_valid && !bus.out_ready));
      chk("out_valid", bus.out_valid, m_valid);
      chk("out_disparity", bus.out_disparity, m_disp);
      chk("out_window_sum", bus.out_window_sum, m_ws);
      chk("out_confident", bus.out_confident, m_conf);
      if (bus.out_valid === 1'b1 && !prev_ov) rises++;
      if (rec && bus.out_valid === 1'b1) pulse_q.push_back(cyc);
      prev_ov = (bus.out_valid === 1'b1);
    end
  end

  // ---------------- driver tasks ----------------
  logic [WS_W-1:0]   pw[NG];
  logic [DISP_W-1:0] pd[NG];

  task automatic send(input logic [WS_W-1:0] ws, input logic [DISP_W-1:0] d, input logic fs);
    int n;
    logic ok;
    bus.in_valid      = 1'b1;
    bus.in_window_sum = ws;
    bus.in_disparity  = d;
    bus.frame_start   = fs;
    n = 0;
    do begin
      @(negedge clock);
      ok = (bus.in_ready === 1'b1);
      @(posedge clock);
      #1;
      n++;
    end while (!ok && n < 40);
    bus.frame_start = 1'b0;
    bus.in_valid    = 1'b0;
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL send_timeout actual=no_accept required=accept time=%0t", $time);
    end
  endtask

  task automatic send_pix();
    for (int i = 0; i < NG; i++) send(pw[i], pd[i], 1'b0);
  endtask

  task automatic lit(input string name, input logic ov, input int d, input int ws, input logic c);
    chk({name, "_valid"}, bus.out_valid, ov);
    chk({name, "_disp"}, bus.out_disparity, d);
    chk({name, "_ws"}, bus.out_window_sum, ws);
    chk({name, "_conf"}, bus.out_confident, c);
  endtask

  task automatic fill_min5();
    // 100, 90, 80 then larger values; group 7 holds the minimum 5 at disp 29
    for (int i = 0; i < NG; i++) begin
      pw[i] = (i < 3) ? WS_W'(100 - 10 * i) : WS_W'(95 + 10 * i);
      pd[i] = DISP_W'(i * 4);
    end
    pw[7] = 14'd5;
    pd[7] = 6'd29;
  endtask

  task automatic fill_tie();
    for (int i = 0; i < NG; i++) begin
      pw[i] = WS_W'(70 + i);
      pd[i] = DISP_W'(i);
    end
    pw[3] = 14'd40; pd[3] = 6'd12;
    pw[9] = 14'd40; pd[9] = 6'd38;
  endtask

  task automatic fill_bp();
    for (int i = 0; i < NG; i++) begin
      pw[i] = WS_W'(500 + i);
      pd[i] = DISP_W'(i);
    end
    pw[10] = 14'd20; pd[10] = 6'd63;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bus.frame_start   = 1'b0;
    bus.in_valid      = 1'b0;
    bus.in_disparity  = '0;
    bus.in_window_sum = '0;
    bus.out_ready     = 1'b1;
    @(posedge clock);
    #1;
    cmp_en = 1'b1;
    @(negedge clock);
    lit("reset", 1'b0, 0, 0, 1'b0);
    chk("reset_in_ready", bus.in_ready, 1'b0);
    @(posedge clock);
    #1;
    reset = 1'b0;

    // Basic pixel: result one cycle after the 16th beat, then consumed.
    fill_min5();
    send_pix();
    @(negedge clock);
    lit("min5", 1'b1, 29, 5, 1'b1);
    @(negedge clock);
    chk("min5_consumed", bus.out_valid, 1'b0);
    @(posedge clock); #1;

    // Tie: earliest of two equal minima wins, margin 0.
    fill_tie();
    send_pix();
    @(negedge clock);
    lit("tie", 1'b1, 12, 40, 1'b0);
    @(posedge clock); #1;

    // Backpressure: result held, next beat stalled while out_ready low.
    bus.out_ready = 1'b0;
    fill_bp();
    send_pix();
    bus.in_valid      = 1'b1;
    bus.in_window_sum = 14'd33;
    bus.in_disparity  = 6'd5;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      chk("bp_stall_ready", bus.in_ready, 1'b0);
      lit("bp_hold", 1'b1, 63, 20, 1'b1);
      @(posedge clock); #1;
    end
    bus.out_ready = 1'b1;
    send(14'd33, 6'd5, 1'b0);
    for (int i = 1; i < NG; i++) send(WS_W'(60 + i), DISP_W'(i + 10), 1'b0);
    @(negedge clock);
    lit("bp_next", 1'b1, 5, 33, 1'b0);
    @(posedge clock); #1;

    // frame_start with a coincident beat restarts the pixel.
    for (int i = 0; i < 5; i++) send(14'd1, DISP_W'(50 + i), 1'b0);
    send(14'd7, 6'd1, 1'b1);
    for (int i = 0; i < NG - 1; i++) begin
      @(negedge clock);
      chk("fs_no_early", bus.out_valid, 1'b0);
      @(posedge clock); #1;
      send(WS_W'(100 + i), DISP_W'(i + 2), 1'b0);
    end
    @(negedge clock);
    lit("fs", 1'b1, 1, 7, 1'b1);
    @(posedge clock); #1;

    // Reset mid-pixel, then a full pixel from scratch.
    for (int i = 0; i < 7; i++) send(14'd2, 6'd9, 1'b0);
    reset = 1'b1;
    @(negedge clock);
    chk("rst_mid_ready", bus.in_ready, 1'b0);
    @(posedge clock); #1;
    @(negedge clock);
    lit("rst_mid", 1'b0, 0, 0, 1'b0);
    @(posedge clock); #1;
    reset = 1'b0;
    for (int i = 0; i < NG; i++) begin
      pw[i] = WS_W'(900 - 5 * i);
      pd[i] = DISP_W'(i);
    end
    send_pix();
    @(negedge clock);
    lit("rst_mid_after", 1'b1, 15, 825, 1'b0);
    @(posedge clock); #1;

    // Reset while a result is pending under backpressure.
    bus.out_ready = 1'b0;
    fill_min5();
    send_pix();
    bus.in_valid      = 1'b1;
    bus.in_window_sum = 14'd3;
    reset = 1'b1;
    @(negedge clock);
    chk("rst_pend_ready", bus.in_ready, 1'b0);
    lit("rst_pend_before", 1'b1, 29, 5, 1'b1);
    @(posedge clock); #1;
    @(negedge clock);
    lit("rst_pend", 1'b0, 0, 0, 1'b0);
    chk("rst_pend_ready2", bus.in_ready, 1'b0);
    @(posedge clock); #1;
    reset = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    fill_tie();
    send_pix();
    @(negedge clock);
    lit("rst_pend_after", 1'b1, 12, 40, 1'b0);
    @(posedge clock); #1;

    // Continuous stream of three pixels.
    pulse_q.delete();
    rec = 1'b1;
    fill_min5(); send_pix();
    fill_tie();  send_pix();
    fill_bp();   send_pix();
    repeat (3) @(posedge clock);
    #1;
    rec = 1'b0;
    chk("stream_pulses", pulse_q.size(), 3);
    if (pulse_q.size() == 3) begin
      chk("stream_gap1", pulse_q[1] - pulse_q[0], 16);
      chk("stream_gap2", pulse_q[2] - pulse_q[1], 16);
    end

    chk("model_results", results, 11);
    chk("dut_results", rises, 11);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1);
  end
endmodule
